occ_gtp_link_ctrl: RTL and testbench

Link bring-up and recovery sequencer for one OCC GTPE2 tile.
- Drives PLL reset, TX/RX GT resets and comma-align enable.
- Waits for PLL lock and reset-done, qualifies the link on received commas, then monitors code errors and restarts the link on failure.
- Sits beside occ_gtpe2_tile and drives its pll_rst_i, txreset_i, rxreset_i and rxencommaalign_i.

---
 rtl/occ_gtp_link_pkg.sv | 36 +++
 rtl/occ_link_sync.sv | 26 ++
 rtl/occ_gtp_link_ctrl.sv | 174 +++++++++++++++++
 tb/tb_occ_gtp_link_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/occ_gtp_link_pkg.sv
// Shared definitions for the OCC GTP link controller: state encodings and a short
// timing set that keeps simulation runs brief.
package occ_gtp_link_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_PLL_WAIT  = 3'd1,
        ST_GT_RST    = 3'd2,
        ST_DONE_WAIT = 3'd3,
        ST_ALIGN     = 3'd4,
        ST_LINK_UP   = 3'd5
    } link_state_e;

    typedef struct packed {
        int unsigned pll_rst_cycles;
        int unsigned gt_rst_cycles;
        int unsigned timeout;
        int unsigned comma_count;
        int unsigned err_max;
        int unsigned err_window;
    } link_timing_t;

    localparam link_timing_t SIM_TIMING = '{
        pll_rst_cycles: 8,
        gt_rst_cycles:  4,
        timeout:        64,
        comma_count:    4,
        err_max:        4,
        err_window:     16
    };

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/occ_link_sync.sv
// Two-flop synchroniser for quasi-static status bits entering the clk_i domain.
module occ_link_sync #(
    parameter int unsigned g_WIDTH = 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [g_WIDTH-1:0] d_i,
    output logic [g_WIDTH-1:0] q_o
);

    logic [g_WIDTH-1:0] meta_q;
    logic [g_WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/occ_gtp_link_ctrl.sv
// Bring-up and recovery sequencer for one OCC GTPE2 tile: drives PLL/GT resets and
// comma alignment, qualifies the link on commas and restarts it on code errors.
module occ_gtp_link_ctrl
    import occ_gtp_link_pkg::*;
#(
    parameter int unsigned g_PLL_RST_CYCLES = 200,
    parameter int unsigned g_GT_RST_CYCLES  = 4,
    parameter int unsigned g_TIMEOUT        = 100000,
    parameter int unsigned g_COMMA_COUNT    = 16,
    parameter int unsigned g_ERR_MAX        = 4,
    parameter int unsigned g_ERR_WINDOW     = 1024
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        restart_i,
    input  logic        pll_lock_i,
    input  logic        txresetdone_i,
    input  logic        rxresetdone_i,
    input  logic        rx_comma_i,
    input  logic        rx_err_i,
    output logic        pll_rst_o,
    output logic        txreset_o,
    output logic        rxreset_o,
    output logic        rxencommaalign_o,
    output logic        link_up_o,
    output logic [2:0]  state_o,
    output logic [15:0] restart_cnt_o
);

    // The state timer also times the reset holds, so it must cover the longest of them.
    localparam int unsigned TMR_W =
        $clog2(max_u(g_TIMEOUT, max_u(g_PLL_RST_CYCLES, g_GT_RST_CYCLES)) + 1);
    localparam int unsigned CMA_W = $clog2(g_COMMA_COUNT + 1);
    localparam int unsigned ERR_W = $clog2(g_ERR_MAX + 1);
    localparam int unsigned WIN_W = $clog2(g_ERR_WINDOW + 1);

    logic [2:0]       status_s;
    logic             lock_s, txdone_s, rxdone_s;
    link_state_e      state_q, state_d;
    logic [TMR_W-1:0] tmo_q, tmo_d;
    logic [CMA_W-1:0] comma_q, comma_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [15:0]      restart_cnt_q, restart_cnt_d;
    logic             restart_evt, tmo_hit, win_roll;
    logic             pll_rst_q, txreset_q, rxreset_q, align_q, link_up_q;

    occ_link_sync #(
        .g_WIDTH (3)
    ) u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     ({pll_lock_i, txresetdone_i, rxresetdone_i}),
        .q_o     (status_s)
    );

    assign lock_s   = status_s[2];
    assign txdone_s = status_s[1];
    assign rxdone_s = status_s[0];
    assign tmo_hit  = (tmo_q == TMR_W'(g_TIMEOUT - 1));
    assign win_roll = (win_q == WIN_W'(g_ERR_WINDOW - 1));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        tmo_d       = (&tmo_q) ? tmo_q : tmo_q + 1'b1;
        comma_d     = comma_q;
        err_d       = err_q;
        win_d       = win_q;
        restart_evt = 1'b0;

        unique case (state_q)
            ST_PLL_RST: begin
                if (tmo_q == TMR_W'(g_PLL_RST_CYCLES - 1)) state_d = ST_PLL_WAIT;
            end
            ST_PLL_WAIT: begin
                if (tmo_hit) begin
                    state_d     = ST_PLL_RST;
                    restart_evt = 1'b1;
                end else if (lock_s) begin
                    state_d = ST_GT_RST;  // normal progress, not a retry
                end
            end
            ST_GT_RST: begin
                if (tmo_q == TMR_W'(g_GT_RST_CYCLES - 1)) state_d = ST_DONE_WAIT;
            end
            ST_DONE_WAIT: begin
                if (tmo_hit) begin
                    state_d     = ST_GT_RST;
                    restart_evt = 1'b1;
                end else if (txdone_s && rxdone_s) begin
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                comma_d = rx_err_i ? '0 : (rx_comma_i ? comma_q + 1'b1 : comma_q);
                if (tmo_hit) begin
                    state_d     = ST_GT_RST;
                    restart_evt = 1'b1;
                end else if (comma_d == CMA_W'(g_COMMA_COUNT)) begin
                    state_d = ST_LINK_UP;
                end
            end
            ST_LINK_UP: begin
                win_d = win_roll ? '0 : win_q + 1'b1;
                if (win_roll)      err_d = rx_err_i ? ERR_W'(1) : '0;
                else if (rx_err_i) err_d = err_q + 1'b1;
                if (err_d == ERR_W'(g_ERR_MAX)) begin
                    state_d     = ST_GT_RST;
                    restart_evt = 1'b1;
                end
            end
            default: state_d = ST_PLL_RST;
        endcase

        if (!lock_s && (state_q inside {ST_GT_RST, ST_DONE_WAIT, ST_ALIGN, ST_LINK_UP})) begin
            state_d     = ST_PLL_RST;
            restart_evt = 1'b1;
        end
        if (restart_i) begin
            state_d     = ST_PLL_RST;
            restart_evt = 1'b1;
        end

        if (restart_i || (state_d != state_q)) begin
            tmo_d   = '0;
            comma_d = '0;
            err_d   = '0;
            win_d   = '0;
        end

        restart_cnt_d = (restart_evt && (restart_cnt_q != 16'hFFFF)) ?
                        restart_cnt_q + 16'd1 : restart_cnt_q;
    end

    // Outputs decode the next state so they change on the same edge as state_q.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_PLL_RST;
            tmo_q         <= '0;
            comma_q       <= '0;
            err_q         <= '0;
            win_q         <= '0;
            restart_cnt_q <= '0;
            pll_rst_q     <= 1'b1;
            txreset_q     <= 1'b0;
            rxreset_q     <= 1'b0;
            align_q       <= 1'b0;
            link_up_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q       <= state_d;
            tmo_q         <= tmo_d;
            comma_q       <= comma_d;
            err_q         <= err_d;
            win_q         <= win_d;
            restart_cnt_q <= restart_cnt_d;
            pll_rst_q     <= (state_d == ST_PLL_RST);
            txreset_q     <= (state_d == ST_GT_RST);
            rxreset_q     <= (state_d == ST_GT_RST);
            align_q       <= (state_d == ST_ALIGN) || (state_d == ST_LINK_UP);
            link_up_q     <= (state_d == ST_LINK_UP);
        end
    end

    assign pll_rst_o        = pll_rst_q;
    assign txreset_o        = txreset_q;
    assign rxreset_o        = rxreset_q;
    assign rxencommaalign_o = align_q;
    assign link_up_o        = link_up_q;
    assign state_o          = state_q;
    assign restart_cnt_o    = restart_cnt_q;

endmodule

// File: tb/tb_occ_gtp_link_ctrl.sv
// Directed bench for occ_gtp_link_ctrl: expectations are queued as stimulus is applied
// and popped against the DUT outputs half a cycle after each active edge.
module tb_occ_gtp_link_ctrl;
    import occ_gtp_link_pkg::*;

    localparam link_timing_t T = SIM_TIMING;

    logic        clk_i = 1'b0;
    logic        rst_n_i, restart_i, pll_lock_i, txresetdone_i, rxresetdone_i;
    logic        rx_comma_i, rx_err_i;
    logic        pll_rst_o, txreset_o, rxreset_o, rxencommaalign_o, link_up_o;
    logic [2:0]  state_o;
    logic [15:0] restart_cnt_o;

    always #5 clk_i = ~clk_i;

    occ_gtp_link_ctrl #(
        .g_PLL_RST_CYCLES (T.pll_rst_cycles),
        .g_GT_RST_CYCLES  (T.gt_rst_cycles),
        .g_TIMEOUT        (T.timeout),
        .g_COMMA_COUNT    (T.comma_count),
        .g_ERR_MAX        (T.err_max),
        .g_ERR_WINDOW     (T.err_window)
    ) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .restart_i        (restart_i),
        .pll_lock_i       (pll_lock_i),
        .txresetdone_i    (txresetdone_i),
        .rxresetdone_i    (rxresetdone_i),
        .rx_comma_i       (rx_comma_i),
        .rx_err_i         (rx_err_i),
        .pll_rst_o        (pll_rst_o),
        .txreset_o        (txreset_o),
        .rxreset_o        (rxreset_o),
        .rxencommaalign_o (rxencommaalign_o),
        .link_up_o        (link_up_o),
        .state_o          (state_o),
        .restart_cnt_o    (restart_cnt_o)
    );

    typedef enum int {SIG_PLL, SIG_TX, SIG_RX, SIG_ALIGN, SIG_LINK, SIG_STATE, SIG_CNT} sig_e;

    typedef struct {
        string       tag;
        sig_e        sig;
        logic [15:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [15:0] observe(input sig_e s);
        case (s)
            SIG_PLL:   return {15'd0, pll_rst_o};
            SIG_TX:    return {15'd0, txreset_o};
            SIG_RX:    return {15'd0, rxreset_o};
            SIG_ALIGN: return {15'd0, rxencommaalign_o};
            SIG_LINK:  return {15'd0, link_up_o};
            SIG_STATE: return {13'd0, state_o};
            default:   return restart_cnt_o;
        endcase
    endfunction

    task automatic push_exp(input string tag, input sig_e s, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [15:0] obs;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = observe(e.sig);
            total++;
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        int n = 0;
        while (state_o !== st && n < budget) begin
            tick(1);
            n++;
        end
        push_exp(tag, SIG_STATE, {13'd0, st});
        check_all();
    endtask

    initial begin
        rst_n_i       = 1'b0;
        restart_i     = 1'b0;
        pll_lock_i    = 1'b0;
        txresetdone_i = 1'b0;
        rxresetdone_i = 1'b0;
        rx_comma_i    = 1'b0;
        rx_err_i      = 1'b0;
        tick(3);
        push_exp("rst_pll", SIG_PLL, 1);
        push_exp("rst_tx", SIG_TX, 0);
        push_exp("rst_align", SIG_ALIGN, 0);
        push_exp("rst_link", SIG_LINK, 0);
        push_exp("rst_state", SIG_STATE, 0);
        push_exp("rst_cnt", SIG_CNT, 0);
        check_all();

        // Power-up: PLL reset hold, lock at cycle 20, resetdone 10 cycles after GT reset.
        rst_n_i = 1'b1;
        tick(7);
        push_exp("pll_hold_c7", SIG_PLL, 1);
        check_all();
        tick(1);
        push_exp("pll_low_c8", SIG_PLL, 0);
        push_exp("pll_wait_state", SIG_STATE, 1);
        check_all();
        tick(12);
        pll_lock_i = 1'b1;
        tick(3);
        push_exp("gt_rst_state", SIG_STATE, 2);
        push_exp("gt_rst_tx", SIG_TX, 1);
        push_exp("gt_rst_rx", SIG_RX, 1);
        check_all();
        tick(4);
        push_exp("done_wait_state", SIG_STATE, 3);
        push_exp("done_wait_tx", SIG_TX, 0);
        check_all();
        tick(6);
        txresetdone_i = 1'b1;
        rxresetdone_i = 1'b1;
        tick(3);
        push_exp("align_state", SIG_STATE, 4);
        push_exp("align_en", SIG_ALIGN, 1);
        check_all();
        for (int i = 1; i <= 4; i++) begin
            rx_comma_i = 1'b1;
            tick(1);
            rx_comma_i = 1'b0;
            push_exp($sformatf("pwr_comma%0d_link", i), SIG_LINK, (i == 4) ? 16'd1 : 16'd0);
            check_all();
        end
        push_exp("pwr_link_state", SIG_STATE, 5);
        push_exp("pwr_link_align", SIG_ALIGN, 1);
        push_exp("pwr_cnt", SIG_CNT, 0);
        check_all();

        // Error windows of 16 cycles: 3 errors in each of two windows, then an error on
        // the rollover cycle plus three more, which must reach the limit of 4.
        for (int j = 1; j <= 35; j++) begin
            rx_err_i = (j inside {2, 3, 4, 17, 18, 19, 32, 33, 34, 35});
            tick(1);
            rx_err_i = 1'b0;
            if (j == 16 || j == 31 || j == 34)
                push_exp($sformatf("win_link_e%0d", j), SIG_LINK, 1);
            if (j == 35) begin
                push_exp("err_gt_state", SIG_STATE, 2);
                push_exp("err_link_down", SIG_LINK, 0);
                push_exp("err_tx", SIG_TX, 1);
                push_exp("err_cnt", SIG_CNT, 1);
            end
            check_all();
        end

        // Realign: 3 commas, one comma+error (counts as error), then 4 commas.
        wait_state("realign_reach", 3'd4, 20);
        for (int k = 0; k < 8; k++) begin
            rx_comma_i = 1'b1;
            rx_err_i   = (k == 3);
            tick(1);
            rx_comma_i = 1'b0;
            rx_err_i   = 1'b0;
            push_exp($sformatf("realign_k%0d_link", k), SIG_LINK, (k == 7) ? 16'd1 : 16'd0);
            if (k == 6) push_exp("realign_k6_state", SIG_STATE, 4);
            if (k == 7) push_exp("realign_k7_state", SIG_STATE, 5);
            check_all();
        end

        // Lock loss in LINK_UP: three edges through the synchroniser and the FSM.
        pll_lock_i = 1'b0;
        tick(2);
        push_exp("lockloss_still_up", SIG_LINK, 1);
        check_all();
        tick(1);
        push_exp("lockloss_state", SIG_STATE, 0);
        push_exp("lockloss_link", SIG_LINK, 0);
        push_exp("lockloss_pll", SIG_PLL, 1);
        push_exp("lockloss_cnt", SIG_CNT, 2);
        check_all();

        // No lock: PLL_WAIT lasts the 64-cycle timeout, then PLL reset again.
        tick(8);
        push_exp("nolock_wait_pll", SIG_PLL, 0);
        push_exp("nolock_wait_state", SIG_STATE, 1);
        check_all();
        tick(63);
        push_exp("nolock_last_wait", SIG_PLL, 0);
        check_all();
        tick(1);
        push_exp("nolock_tmo1_pll", SIG_PLL, 1);
        push_exp("nolock_tmo1_cnt", SIG_CNT, 3);
        check_all();
        tick(71);
        push_exp("nolock_pre_tmo2_cnt", SIG_CNT, 3);
        push_exp("nolock_pre_tmo2_state", SIG_STATE, 1);
        check_all();
        tick(1);
        push_exp("nolock_tmo2_cnt", SIG_CNT, 4);
        push_exp("nolock_tmo2_pll", SIG_PLL, 1);
        check_all();

        // restart_i in DONE_WAIT.
        pll_lock_i    = 1'b1;
        txresetdone_i = 1'b0;
        rxresetdone_i = 1'b0;
        wait_state("reach_done_wait", 3'd3, 40);
        tick(3);
        restart_i = 1'b1;
        tick(1);
        restart_i = 1'b0;
        push_exp("restart_state", SIG_STATE, 0);
        push_exp("restart_pll", SIG_PLL, 1);
        push_exp("restart_cnt", SIG_CNT, 5);
        check_all();

        // Synchronous reset in the middle of ALIGN.
        txresetdone_i = 1'b1;
        rxresetdone_i = 1'b1;
        wait_state("reach_align", 3'd4, 60);
        for (int i = 0; i < 2; i++) begin
            rx_comma_i = 1'b1;
            tick(1);
            rx_comma_i = 1'b0;
        end
        rst_n_i = 1'b0;
        tick(1);
        push_exp("midrst_pll", SIG_PLL, 1);
        push_exp("midrst_tx", SIG_TX, 0);
        push_exp("midrst_rx", SIG_RX, 0);
        push_exp("midrst_align", SIG_ALIGN, 0);
        push_exp("midrst_link", SIG_LINK, 0);
        push_exp("midrst_state", SIG_STATE, 0);
        push_exp("midrst_cnt", SIG_CNT, 0);
        check_all();
        rst_n_i = 1'b1;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
